// File: rtl/alu_issue.sv
// Operand-fetch/issue stage for the 16-bit ALU: 8-entry register file, result captured one cycle after accept, issue every 3 cycles minimum.
// Result is held in RESP until res_ready; no new command is taken meanwhile. `ALU_ISSUE_FLAGS_EN adds res_zero/res_neg.
module alu_issue #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [0:2]        cmd_op,
  input  logic [0:ADDR_W-1] cmd_rd,
  input  logic [0:ADDR_W-1] cmd_rs1,
  input  logic [0:ADDR_W-1] cmd_rs2,
  input  logic              wr_en,
  input  logic [0:ADDR_W-1] wr_addr,
  input  logic [0:WIDTH-1]  wr_data,
  output logic [0:WIDTH-1]  alu_a,
  output logic [0:WIDTH-1]  alu_b,
  output logic [0:2]        alu_op,
  input  logic [0:WIDTH-1]  alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [0:WIDTH-1]  res_data,
  output logic [0:ADDR_W-1] res_rd
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              res_zero,
  output logic              res_neg
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              unary;
  logic              wb;
  logic [0:WIDTH-1]  rf [0:2**ADDR_W-1];

  assign cmd_ready = (state == IDLE) && !rst;
  assign res_valid = (state == RESP);
  assign unary     = (cmd_op == 3'b010) || (cmd_op == 3'b011) || (cmd_op == 3'b111);
  assign wb        = (state == EXEC);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      res_data <= '0;
      res_rd   <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
`endif
      for (int i = 0; i < 2**ADDR_W; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a  <= rf[cmd_rs1];
        alu_b  <= unary ? '0 : rf[cmd_rs2];
        alu_op <= cmd_op;
        res_rd <= cmd_rd;
      end
      if (wb) begin
        res_data   <= alu_out;
        rf[res_rd] <= alu_out;
`ifdef ALU_ISSUE_FLAGS_EN
        res_zero   <= (alu_out == '0);
        res_neg    <= alu_out[0];
`endif
      end
      // ALU writeback takes priority over a direct write to the same register
      if (wr_en && !(wb && (wr_addr == res_rd))) rf[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Randomised scoreboard bench for alu_issue with an in-bench ALU and register-file reference model.
module tb_alu_issue;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [0:2]   cmd_op = '0;
  logic [0:2]   cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic         wr_en = 1'b0;
  logic [0:2]   wr_addr = '0;
  logic [0:W-1] wr_data = '0;
  logic [0:W-1] alu_a, alu_b, alu_out;
  logic [0:2]   alu_op;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [0:W-1] res_data;
  logic [0:2]   res_rd;
`ifdef ALU_ISSUE_FLAGS_EN
  logic         res_zero, res_neg;
`endif

  alu_issue dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd)
`ifdef ALU_ISSUE_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [0:W-1] alu_f(input logic [0:2] op, input logic [0:W-1] a, input logic [0:W-1] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a + 16'd1;
      3'd3: return a - 16'd1;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic bit is_unary(input logic [0:2] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd7);
  endfunction

  always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [0:W-1] d;
    logic [0:2]   rd;
  } res_t;
  res_t sb[$];

  // Reference model: register contents plus the single outstanding command
  logic [0:W-1] rf_m [0:7];
  bit           busy = 0, pend_exec = 0, pend_resp = 0, wb;
  logic [0:W-1] ea, eb, r;
  logic [0:2]   eop, erd;

  always @(negedge clk) begin
    wb = 0;
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_m[i] = '0;
      busy = 0; pend_exec = 0; pend_resp = 0;
      sb.delete();
      chk("cmd_ready_in_rst", cmd_ready, 0);
    end else begin
      chk("cmd_ready", cmd_ready, !busy);
      chk("res_valid", res_valid, pend_resp);
      if (pend_exec) begin
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eop);
        r = alu_f(eop, ea, eb);
        sb.push_back('{d: r, rd: erd});
        rf_m[erd] = r;
        wb = 1;
        pend_exec = 0;
        pend_resp = 1;
      end else if (pend_resp) begin
        if (res_ready) begin
          pend_resp = 0;
          busy = 0;
        end
      end else if (cmd_valid) begin
        ea  = rf_m[cmd_rs1];
        eb  = is_unary(cmd_op) ? '0 : rf_m[cmd_rs2];
        eop = cmd_op;
        erd = cmd_rd;
        pend_exec = 1;
        busy = 1;
      end
      if (wr_en && !(wb && wr_addr == erd)) rf_m[wr_addr] = wr_data;
    end
  end

  // Result monitor: every RESP cycle must show the queue head; pop on handshake
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("res_data", res_data, sb[0].d);
        chk("res_rd", res_rd, sb[0].rd);
`ifdef ALU_ISSUE_FLAGS_EN
        chk("res_zero", res_zero, sb[0].d == '0);
        chk("res_neg", res_neg, sb[0].d[0]);
`endif
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  bit rnd = 0;
  always @(posedge clk) begin
    if (rnd) begin
      #1;
      res_ready = ($urandom_range(3) != 0);
      wr_en     = ($urandom_range(3) == 0);
      wr_addr   = 3'($urandom_range(7));
      wr_data   = 16'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [0:2] a, input logic [0:W-1] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic start_cmd(input logic [0:2] op, input logic [0:2] rd, input logic [0:2] rs1, input logic [0:2] rs2);
    cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
  endtask

  task automatic wait_acc(output int n);
    bit acc = 0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready && cmd_valid;
      step();
      n++;
    end
    if (!acc) chk("cmd_accept_timeout", 0, 1);
    cmd_valid = 0;
  endtask

  task automatic issue(input logic [0:2] op, input logic [0:2] rd, input logic [0:2] rs1, input logic [0:2] rs2);
    int n;
    start_cmd(op, rd, rs1, rs2);
    wait_acc(n);
  endtask

  task automatic expect_res(input string name, input logic [0:W-1] d, input logic [0:2] rd);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = res_valid;
      n++;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_data"}, res_data, d);
      chk({name, "_rd"}, res_rd, rd);
    end
    step();
  endtask

  initial begin
    int n;
    repeat (2) step();
    rst = 0;
    step();

    wr(3'd1, 16'd64);
    wr(3'd2, 16'd32);
    issue(3'd0, 3'd3, 3'd1, 3'd2);
    chk("add_alu_a", alu_a, 16'd64);
    chk("add_alu_b", alu_b, 16'd32);
    expect_res("add", 16'd96, 3'd3);

    issue(3'd1, 3'd4, 3'd2, 3'd1);
    expect_res("sub", 16'hFFE0, 3'd4);
    wr(3'd7, 16'hFFFF);
    issue(3'd2, 3'd5, 3'd7, 3'd0);
    expect_res("inc", 16'h0000, 3'd5);
    wr(3'd1, 16'h1F87);
    issue(3'd7, 3'd6, 3'd1, 3'd2);
    chk("not_alu_b", alu_b, 16'h0000);
    expect_res("not", 16'hE078, 3'd6);

    // Stall in RESP with a second command waiting
    res_ready = 0;
    issue(3'd5, 3'd0, 3'd3, 3'd4);
    start_cmd(3'd0, 3'd1, 3'd1, 3'd1);
    repeat (6) step();
    res_ready = 1;
    wait_acc(n);
    chk("stall_accept_latency", n, 2);

    // Direct write colliding with writeback, then a non-colliding one
    issue(3'd0, 3'd3, 3'd1, 3'd2);
    wr(3'd3, 16'h1234);
    expect_res("collide", 16'h3F2E, 3'd3);
    issue(3'd5, 3'd7, 3'd3, 3'd3);
    expect_res("collide_rb", 16'h3F2E, 3'd7);
    issue(3'd6, 3'd4, 3'd1, 3'd2);
    wr(3'd5, 16'hABCD);
    expect_res("xor", 16'h3F2E, 3'd4);
    issue(3'd5, 3'd5, 3'd5, 3'd5);
    expect_res("side_write_rb", 16'hABCD, 3'd5);

    // Reset while a command is executing
    issue(3'd0, 3'd6, 3'd1, 3'd2);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_res_valid", res_valid, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      issue(3'd5, 3'(i), 3'(i), 3'(i));
      expect_res("rst_rb", 16'h0000, 3'(i));
    end

    rnd = 1;
    for (int k = 0; k < 300; k++) begin
      issue(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)));
      repeat ($urandom_range(2)) step();
    end
    rnd = 0;
    step();
    res_ready = 1;
    wr_en = 0;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-fetch and issue stage that sits directly upstream of the 16-bit ALU. Holds an 8-entry general register file and accepts commands over a valid/ready handshake. Drives the ALU operands and opcode from registers, captures the combinational ALU result, writes it back to the destination register, and presents it on a result handshake. One command is in flight at a time.

## Interface
Parameters:
- WIDTH, 16, datapath width; must match the ALU.
- ADDR_W, 3, register address width; register count is 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB (a-b), 010 INC, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 NOT (a).
- cmd_rd  in  ADDR_W  destination register.
- cmd_rs1  in  ADDR_W  source register for operand a.
- cmd_rs2  in  ADDR_W  source register for operand b.
- wr_en  in  1  direct register write strobe.
- wr_addr  in  ADDR_W  direct write address.
- wr_data  in  WIDTH  direct write data.
- alu_a  out  WIDTH  ALU operand a, registered.
- alu_b  out  WIDTH  ALU operand b, registered.
- alu_op  out  3  ALU opcode, registered.
- alu_out  in  WIDTH  combinational ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  captured result.
- res_rd  out  ADDR_W  destination of the result.
- All vectors are declared MSB-first as [0:N-1]. Bit 0 is the MSB, matching the ALU.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = !rst.
  - On cmd_valid && cmd_ready: alu_a <= rf[rs1], alu_op <= cmd_op, res_rd <= cmd_rd, then go to EXEC.
  - alu_b <= rf[rs2] for opcodes 000, 001, 100, 101, 110. alu_b <= 0 for unary opcodes 010, 011, 111; rs2 is ignored.
- EXEC:
  - ALU settles combinationally.
  - res_data <= alu_out and rf[res_rd] <= alu_out, then go to RESP.
- RESP:
  - res_valid = 1, with res_data and res_rd held stable.
  - On res_ready, go to IDLE.
  - If res_ready stays low, RESP holds indefinitely and cmd_ready stays 0.
- Arithmetic is modulo 2**WIDTH, with no carry or overflow output.
- Register reads in IDLE return the value before any same-edge write; there is no bypass.
- Direct writes:
  - Honoured in every state.
  - In EXEC with wr_addr == res_rd, the ALU writeback wins and wr_data is dropped.
  - A write to a different address in the same cycle completes normally.
- Reset:
  - State goes to IDLE and all rf entries are cleared to 0.
  - alu_a, alu_b, alu_op, res_data and res_rd go to 0; res_valid goes to 0.
  - An in-flight command is discarded with no writeback.
  - A direct write in the reset cycle is ignored.

## Timing
- Command accepted at edge E0.
- alu_a, alu_b and alu_op are valid during the cycle after E0 (EXEC).
- Result is written to rf and res_data at edge E1 = E0+1.
- res_valid is high from E1.
- If res_ready is high in the first RESP cycle, cmd_ready is high again after edge E2.
- Minimum issue interval is 3 cycles.
- cmd_ready, res_valid and cmd_ready's reset gating are the only combinational outputs; all others are registered.

## Configuration
- Macro: ALU_ISSUE_FLAGS_EN.
- Defined: adds output res_zero (1 bit) and output res_neg (1 bit).
  - Both are captured at E1 alongside res_data.
  - res_zero = (alu_out == 0); res_neg = alu_out[0], the MSB.
  - Both reset to 0 and are held through RESP.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then write r1=64 and r2=32. Issue ADD rd=3 rs1=1 rs2=2 → alu_a=64, alu_b=32 in EXEC; res_valid high one cycle later with res_data=96, res_rd=3; r3 reads back 96.
- SUB rd=4 rs1=2 rs2=1 → res_data=0xFFE0. Write r7=0xFFFF, then INC rd=5 rs1=7 → res_data=0. With flags enabled, SUB gives res_neg=1 and INC gives res_zero=1.
- NOT rd=6 rs1=r1 (value 0x1F87) rs2=2 → alu_b=0 during EXEC, res_data=0xE078.
- Complete a result, then hold res_ready low for 5 cycles → res_valid, res_data and res_rd stay stable; cmd_ready stays 0; a command held on cmd_valid is not accepted until the cycle after res_ready.
- In EXEC, assert wr_en with wr_addr == res_rd and wr_data=0x1234 → rf holds the ALU result. Repeat with a different wr_addr → both writes land.
- Assert rst during EXEC → no writeback, all rf reads return 0, res_valid=0, and cmd_ready=1 in the cycle after rst deasserts.
